// File: rtl/vga_timing_gen.sv
// Raster timing generator: chained x/y counters with registered sync, data-enable
// and line/frame start pulses, advanced by a pixel clock-enable.
module vga_timing_gen #(
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned H_FRONT = 48,
  parameter int unsigned H_SYNC  = 112,
  parameter int unsigned H_BACK  = 248,
  parameter int unsigned V_DISP  = 1024,
  parameter int unsigned V_FRONT = 1,
  parameter int unsigned V_SYNC  = 3,
  parameter int unsigned V_BACK  = 38,
  parameter bit          H_POL   = 1'b1,
  parameter bit          V_POL   = 1'b1,
  parameter int unsigned CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          resync,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_DISP);
  localparam logic [CW-1:0] V_ACT    = CW'(V_DISP);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_DISP + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_DISP + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISP + V_FRONT + V_SYNC);

  logic [CW-1:0] x_d, y_d;
  logic          line_start_d, frame_start_d;
  logic          hsync_d, vsync_d, de_d;

  always_comb begin
    x_d           = x;
    y_d           = y;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (resync) begin
      x_d = H_LAST;
      y_d = V_LAST;
    end else if (ce) begin
      if (x == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y + CW'(1);
        end
      end else begin
        x_d = x + CW'(1);
      end
    end
    // Decode from the next position so the registered outputs line up with x/y.
    hsync_d = ((x_d >= HS_BEGIN) && (x_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d = ((y_d >= VS_BEGIN) && (y_d < VS_END)) ? V_POL : ~V_POL;
    de_d    = (x_d < H_ACT) && (y_d < V_ACT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_d;
      y           <= y_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a linear-position model checks every cycle, directed
// scenarios pin region boundaries, pulse spacing, clock-enable, resync and reset.
module tb_vga_timing_gen;

  localparam int A_HD = 15, A_HF = 1, A_HS = 3, A_HB = 10, A_HT = 29;
  localparam int A_VD = 4, A_VF = 1, A_VS = 2, A_VB = 3, A_VT = 10;
  localparam int B_HD = 1280, B_HF = 48, B_HS = 112, B_HB = 248, B_HT = 1688;
  localparam int B_VD = 4, B_VF = 1, B_VS = 3, B_VB = 2, B_VT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ce_a, resync_a, rst_b;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [4:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [11:0] x_b, y_b;

  int vec  = 0;
  int errs = 0;

  vga_timing_gen #(
    .H_DISP(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_DISP(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(5)
  ) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .resync(resync_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .V_DISP(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(12)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ce(1'b1), .resync(1'b0),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  task automatic cmp(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs from the linear pixel index p within the frame.
  task automatic check_outputs(input string tag, input int p, input bit adv,
                               input int hd, input int hf, input int hs, input int ht,
                               input int vd, input int vf, input int vs, input bit hp,
                               input bit vp, input int ax, input int ay, input bit ahs,
                               input bit avs, input bit ade, input bit als, input bit afs);
    int ex;
    int ey;
    bit ehs;
    bit evs;
    ex  = p % ht;
    ey  = p / ht;
    ehs = (ex >= hd + hf && ex < hd + hf + hs) ? hp : !hp;
    evs = (ey >= vd + vf && ey < vd + vf + vs) ? vp : !vp;
    cmp({tag, ".x"}, ax, ex);
    cmp({tag, ".y"}, ay, ey);
    cmp({tag, ".hsync"}, int'(ahs), int'(ehs));
    cmp({tag, ".vsync"}, int'(avs), int'(evs));
    cmp({tag, ".de"}, int'(ade), int'(ex < hd && ey < vd));
    cmp({tag, ".line_start"}, int'(als), int'(adv && ex == 0));
    cmp({tag, ".frame_start"}, int'(afs), int'(adv && p == 0));
  endtask

  int  pa = A_HT * A_VT - 1;
  bit  adva = 1'b0;
  always @(posedge clk) begin
    if (!rst_a || resync_a) begin
      pa   = A_HT * A_VT - 1;
      adva = 1'b0;
    end else if (ce_a) begin
      pa   = (pa + 1) % (A_HT * A_VT);
      adva = 1'b1;
    end else begin
      adva = 1'b0;
    end
    #1;
    check_outputs("model_a", pa, adva, A_HD, A_HF, A_HS, A_HT, A_VD, A_VF, A_VS, 1'b1, 1'b1,
                  int'(x_a), int'(y_a), hs_a, vs_a, de_a, ls_a, fs_a);
  end

  int  pb = B_HT * B_VT - 1;
  bit  advb = 1'b0;
  always @(posedge clk) begin
    if (!rst_b) begin
      pb   = B_HT * B_VT - 1;
      advb = 1'b0;
    end else begin
      pb   = (pb + 1) % (B_HT * B_VT);
      advb = 1'b1;
    end
    #1;
    check_outputs("model_b", pb, advb, B_HD, B_HF, B_HS, B_HT, B_VD, B_VF, B_VS, 1'b0, 1'b0,
                  int'(x_b), int'(y_b), hs_b, vs_b, de_b, ls_b, fs_b);
  end

  task automatic run_a();
    int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt;
    int nfs, vs_cnt, vs_ymin, vs_ymax, bad_edge, de_bad, ls_wide, ls_in_frame;
    int fs_t[2];
    bit vs_prev, ls_prev, found;
    // Reset release
    repeat (5) @(negedge clk);
    cmp("rst.x", int'(x_a), 28);
    cmp("rst.y", int'(y_a), 9);
    cmp("rst.de", int'(de_a), 0);
    cmp("rst.hsync", int'(hs_a), 0);
    rst_a = 1'b1;
    tick();
    cmp("rel.x", int'(x_a), 0);
    cmp("rel.y", int'(y_a), 0);
    cmp("rel.de", int'(de_a), 1);
    cmp("rel.frame_start", int'(fs_a), 1);
    cmp("rel.line_start", int'(ls_a), 1);
    // One line
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int i = 0; i < A_HT; i++) begin
      if (de_a) de_cnt++;
      if (hs_a) begin
        if (hs_first < 0) hs_first = int'(x_a);
        hs_last = int'(x_a);
        hs_cnt++;
      end
      if (ls_a) ls_cnt++;
      tick();
    end
    cmp("line.de_cycles", de_cnt, 15);
    cmp("line.hsync_first_x", hs_first, 16);
    cmp("line.hsync_last_x", hs_last, 18);
    cmp("line.hsync_cycles", hs_cnt, 3);
    cmp("line.ls_per_line", ls_cnt, 1);
    cmp("line.ls_period29", int'(ls_a), 1);
    cmp("line.next_y", int'(y_a), 1);
    // Two frames
    nfs = 0; vs_cnt = 0; vs_ymin = 99; vs_ymax = -1; bad_edge = 0; de_bad = 0;
    vs_prev = vs_a;
    for (int i = 0; i < 600; i++) begin
      if (fs_a) begin
        if (nfs < 2) fs_t[nfs] = i;
        nfs++;
      end
      if (nfs == 1 && vs_a) begin
        vs_cnt++;
        if (int'(y_a) < vs_ymin) vs_ymin = int'(y_a);
        if (int'(y_a) > vs_ymax) vs_ymax = int'(y_a);
      end
      if (vs_a != vs_prev && !ls_a) bad_edge++;
      vs_prev = vs_a;
      if (de_a && y_a >= 4) de_bad++;
      tick();
    end
    cmp("frame.fs_count", nfs, 2);
    if (nfs >= 2) cmp("frame.fs_spacing", fs_t[1] - fs_t[0], 290);
    cmp("frame.vsync_cycles", vs_cnt, 58);
    cmp("frame.vsync_ymin", vs_ymin, 5);
    cmp("frame.vsync_ymax", vs_ymax, 6);
    cmp("frame.vsync_edge_off_ls", bad_edge, 0);
    cmp("frame.de_in_vblank", de_bad, 0);
    // Clock enable at 1-of-3
    nfs = 0; ls_wide = 0; ls_in_frame = 0; ls_prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (fs_a) begin
        if (nfs < 2) fs_t[nfs] = i;
        nfs++;
      end
      if (nfs == 1 && ls_a) ls_in_frame++;
      if (ls_a && ls_prev) ls_wide++;
      ls_prev = ls_a;
      ce_a = (i % 3 == 0);
      tick();
    end
    ce_a = 1'b1;
    cmp("ce.fs_count", nfs, 2);
    if (nfs >= 2) cmp("ce.fs_spacing", fs_t[1] - fs_t[0], 870);
    cmp("ce.ls_wider_than_1clk", ls_wide, 0);
    cmp("ce.ls_per_frame", ls_in_frame, 10);
    // Resync at (7,2)
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (x_a == 5'd7 && y_a == 5'd2) found = 1'b1;
      else tick();
    end
    cmp("resync.reached_7_2", int'(found), 1);
    resync_a = 1'b1;
    tick();
    resync_a = 1'b0;
    cmp("resync.x", int'(x_a), 28);
    cmp("resync.y", int'(y_a), 9);
    cmp("resync.frame_start", int'(fs_a), 0);
    cmp("resync.line_start", int'(ls_a), 0);
    tick();
    cmp("resync.next_fs", int'(fs_a), 1);
    cmp("resync.next_x", int'(x_a), 0);
    cmp("resync.next_y", int'(y_a), 0);
  endtask

  task automatic run_b();
    int hs_cnt, hs_first, hs_last, vs_cnt;
    repeat (5) @(negedge clk);
    cmp("b.rst.x", int'(x_b), 1687);
    cmp("b.rst.hsync", int'(hs_b), 1);
    cmp("b.rst.vsync", int'(vs_b), 1);
    rst_b = 1'b1;
    tick();
    cmp("b.rel.frame_start", int'(fs_b), 1);
    hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0;
    for (int i = 0; i < B_HT * B_VT; i++) begin
      if (!hs_b && i < B_HT) begin
        if (hs_first < 0) hs_first = int'(x_b);
        hs_last = int'(x_b);
        hs_cnt++;
      end
      if (!vs_b) vs_cnt++;
      tick();
    end
    cmp("b.hsync_low_cycles", hs_cnt, 112);
    cmp("b.hsync_first_x", hs_first, 1328);
    cmp("b.hsync_last_x", hs_last, 1439);
    cmp("b.vsync_low_cycles", vs_cnt, 3 * 1688);
    cmp("b.frame_wrap_fs", int'(fs_b), 1);
    repeat (2000) tick();
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    cmp("b.midrst.x", int'(x_b), 1687);
    cmp("b.midrst.y", int'(y_b), 9);
    cmp("b.midrst.hsync", int'(hs_b), 1);
    cmp("b.midrst.vsync", int'(vs_b), 1);
    cmp("b.midrst.de", int'(de_b), 0);
    cmp("b.midrst.ls", int'(ls_b), 0);
    cmp("b.midrst.fs", int'(fs_b), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    tick();
    cmp("b.rerel.fs", int'(fs_b), 1);
    cmp("b.rerel.x", int'(x_b), 0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ce_a = 1'b1;
    resync_a = 1'b0;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator producing horizontal and vertical sync, data-enable and pixel coordinates for one video output. It replaces the separate per-axis `stm_timing` instances with a single block. The vertical counter is chained to the horizontal line wrap, and sync polarity is configurable. A pixel clock-enable and a frame resync input are added. It sits between the system clock domain (108 MHz for the default mode) and the pixel pipeline / DAC interface.

## Interface

**Parameters**
- `H_DISP`, 1280: active pixels per line.
- `H_FRONT`, 48: horizontal front porch, in pixels.
- `H_SYNC`, 112: hsync pulse width, in pixels.
- `H_BACK`, 248: horizontal back porch, in pixels.
- `V_DISP`, 1024: active lines per frame.
- `V_FRONT`, 1: vertical front porch, in lines.
- `V_SYNC`, 3: vsync pulse width, in lines.
- `V_BACK`, 38: vertical back porch, in lines.
- `H_POL`, 1: asserted level of `hsync`.
- `V_POL`, 1: asserted level of `vsync`.
- `CW`, 12: counter and coordinate width. Must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL).
- Constraint: every porch and sync parameter is ≥ 1.

**Ports**
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `ce`, input, 1: pixel enable. The raster advances only on `clk` edges where `ce`=1.
- `resync`, input, 1: synchronous request to restart the frame.
- `hsync`, output, 1: horizontal sync at polarity `H_POL`.
- `vsync`, output, 1: vertical sync at polarity `V_POL`.
- `de`, output, 1: high inside the active area.
- `x`, output, CW: current horizontal count.
- `y`, output, CW: current vertical count.
- `line_start`, output, 1: one-cycle pulse when `x` becomes 0.
- `frame_start`, output, 1: one-cycle pulse when `x`=0 and `y`=0 are entered.

## Operation

**Totals**
- H_TOTAL = H_DISP+H_FRONT+H_SYNC+H_BACK.
- V_TOTAL likewise from the V_ parameters.

**Horizontal regions of `x`, in order**
- display: [0, H_DISP)
- front porch: [H_DISP, H_DISP+H_FRONT)
- sync: [H_DISP+H_FRONT, H_DISP+H_FRONT+H_SYNC)
- back porch: the remainder up to H_TOTAL-1.
- Vertical regions of `y` follow the same order using the V_ parameters.

**Counter behaviour**
- `x` counts 0..H_TOTAL-1 and wraps to 0.
- `y` increments only on the `x` wrap, counts 0..V_TOTAL-1, and wraps to 0.

**Output decode**
- `hsync` = H_POL while `x` is in the horizontal sync region, otherwise ~H_POL.
- `vsync` = V_POL while `y` is in the vertical sync region, otherwise ~V_POL. `vsync` therefore changes only together with a line start.
- `de` = (`x` < H_DISP) && (`y` < V_DISP).

**Registering**
- All outputs are registers. `hsync`, `vsync` and `de` are always consistent with the `x`/`y` values presented in the same cycle, with no decode glitches.
- Counter arithmetic is unsigned, CW bits wide. Terminal compare is equality against TOTAL-1; wrap is never produced by overflow.

**Clock enable**
- `ce`=0: `x`, `y`, `hsync`, `vsync` and `de` hold their values.
- `line_start` and `frame_start` are forced to 0 on any cycle that does not follow an advancing edge.

**Resync**
- `resync`=1 on an edge loads `x`=H_TOTAL-1 and `y`=V_TOTAL-1 and clears both pulses, regardless of `ce`.
- The next `ce` edge then enters (0,0) with `frame_start`.
- `resync` takes priority over `ce`.

**Reset**
- While `rst`=0, outputs are forced immediately (asynchronously) to:
  - `x`=H_TOTAL-1, `y`=V_TOTAL-1
  - `hsync`=~H_POL, `vsync`=~V_POL
  - `de`=0, `line_start`=0, `frame_start`=0
- This is the back-porch/back-porch position, so it is valid because H_BACK ≥ 1 and V_BACK ≥ 1.
- Reset asserted mid-frame aborts the frame. There is no partial-line completion.

## Timing

- Reset release: the first `clk` edge with `ce`=1 sets `x`=0, `y`=0, `de`=1, `line_start`=1 and `frame_start`=1.
- With `ce` held at 1, one pixel advances per `clk`:
  - line period = H_TOTAL cycles; frame period = H_TOTAL·V_TOTAL cycles.
  - Default mode: 1688·1066 cycles.
- `line_start` is high for exactly one `clk` cycle per line; `frame_start` for one cycle per frame, coincident with a `line_start`.
- With a gated `ce`, pulses last one `clk` cycle, never one pixel period.
- `hsync` asserts on the cycle `x` = H_DISP+H_FRONT and lasts H_SYNC advancing edges.
- `vsync` asserts on the same cycle as `line_start` for `y` = V_DISP+V_FRONT and lasts V_SYNC lines.
- There is no pipeline latency between `x`/`y` and the decoded outputs (0 cycles).

## Test plan

Tests 1–5 use H=15/1/3/10 (H_TOTAL=29), V=4/1/2/3 (V_TOTAL=10), CW=5, `ce`=1 unless noted.

1. **Reset release:** release `rst` after 5 cycles.
   - During reset: `x`=28, `y`=9, `de`=0, `hsync`=0.
   - First edge: `x`=0, `y`=0, `de`=1, `frame_start`=1, `line_start`=1.
2. **Line decode:** run one line.
   - `de` high for cycles 0–14.
   - `hsync` high for `x`=16..18.
   - `line_start` recurs after exactly 29 cycles.
3. **Frame decode:** run 2 frames.
   - `vsync` high exactly for `y`=5..6, with edges coincident with `line_start`.
   - `frame_start` is 290 cycles apart.
   - `de` never high when `y` ≥ 4.
4. **Clock enable:** drive `ce` at 1-of-3.
   - Counters advance only on enabled edges.
   - `line_start` is 1 `clk` wide.
   - `frame_start` spacing is 870 cycles.
5. **Resync:** pulse `resync` at `x`=7, `y`=2 with `ce`=1.
   - Next state: `x`=28, `y`=9.
   - Following edge: `frame_start`=1.
6. **Polarity, default geometry:** H_POL=0, V_POL=0, default geometry.
   - `hsync` low for 112 cycles at `x`=1328..1439.
   - `vsync` low for 3 lines.
   - Mid-frame `rst` pulse returns all outputs to their reset values immediately.
